// File: rtl/stage_if_if.sv
// Fetch-stage bus: instruction-memory port, decode-side outputs and the
// stall/redirect controls coming back from downstream.
interface stage_if_if #(
  parameter int unsigned pc_width   = 9,
  parameter int unsigned inst_width = 32
);
  logic                  stall;
  logic                  branch_taken;
  logic [pc_width-1:0]   branch_target;
  logic                  jump;
  logic [pc_width-1:0]   jump_target;
  logic [pc_width-1:0]   imem_addr;
  logic [inst_width-1:0] imem_rdata;
  logic [inst_width-1:0] inst;
  logic [pc_width-1:0]   pc_out;
  logic                  inst_valid;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    output imem_addr, inst, pc_out, inst_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    input  imem_addr, inst, pc_out, inst_valid
  );
endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and hands inst/pc_out/inst_valid to decode with stall hold and redirect squash.
//
// state | meaning
// BOOT  | no usable fetch in flight (after reset or redirect); outputs a bubble
// RUN   | imem_rdata is the instruction at fetch_pc_q; passed straight through
// HOLD  | downstream stalled; outputs replayed from the hold registers
module stage_if #(
  parameter int unsigned           pc_width   = 9,
  parameter int unsigned           inst_width = 32,
  parameter logic [pc_width-1:0]   reset_pc   = '0,
  parameter logic [inst_width-1:0] nop_inst   = '0
) (
  input logic        clk,
  input logic        reset,
  stage_if_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t                state, state_nxt;
  logic [pc_width-1:0]   pc_q, pc_nxt;
  logic [pc_width-1:0]   fetch_pc_q, fetch_pc_nxt;
  logic [pc_width-1:0]   hold_pc_q, hold_pc_nxt;
  logic [inst_width-1:0] hold_inst_q, hold_inst_nxt;
  logic                  hold_valid_q, hold_valid_nxt;

  logic [inst_width-1:0] inst_mux;
  logic [pc_width-1:0]   pc_mux;
  logic                  valid_mux;

  logic                  redirect;
  logic [pc_width-1:0]   redirect_pc;

  // jump outranks branch when both arrive together
  assign redirect    = bus.jump | bus.branch_taken;
  assign redirect_pc = bus.jump ? bus.jump_target : bus.branch_target;

  always_comb begin
    inst_mux  = nop_inst;
    pc_mux    = fetch_pc_q;
    valid_mux = 1'b0;
    unique case (state)
      RUN: begin
        inst_mux  = bus.imem_rdata;
        valid_mux = 1'b1;
      end
      HOLD: begin
        inst_mux  = hold_inst_q;
        pc_mux    = hold_pc_q;
        valid_mux = hold_valid_q;
      end
      default: ;
    endcase
  end

  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_mux;
  assign bus.pc_out     = pc_mux;
  assign bus.inst_valid = valid_mux;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc_q;
    fetch_pc_nxt   = fetch_pc_q;
    hold_inst_nxt  = hold_inst_q;
    hold_pc_nxt    = hold_pc_q;
    hold_valid_nxt = hold_valid_q;
    if (redirect) begin
      // redirect beats stall; the fetch already in flight is squashed via BOOT
      pc_nxt         = redirect_pc;
      state_nxt      = BOOT;
      hold_inst_nxt  = '0;
      hold_pc_nxt    = '0;
      hold_valid_nxt = 1'b0;
    end else if (bus.stall) begin
      if (state == RUN) begin
        hold_inst_nxt  = inst_mux;
        hold_pc_nxt    = pc_mux;
        hold_valid_nxt = valid_mux;
        state_nxt      = HOLD;
      end
    end else begin
      // in HOLD the replayed output is consumed this cycle; memory already
      // re-reads pc_q, so advancing here neither skips nor repeats
      pc_nxt       = pc_q + 1'b1;
      fetch_pc_nxt = pc_q;
      state_nxt    = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      pc_q         <= reset_pc;
      fetch_pc_q   <= '0;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc_q         <= pc_nxt;
      fetch_pc_q   <= fetch_pc_nxt;
      hold_inst_q  <= hold_inst_nxt;
      hold_pc_q    <= hold_pc_nxt;
      hold_valid_q <= hold_valid_nxt;
    end
  end
endmodule
